// File: rtl/noc_pkg.sv
// Shared NoC router parameters and types.
package noc_pkg;

  localparam int unsigned PORT_N    = 5;
  localparam int unsigned PORT_W    = 3;
  localparam int unsigned BUF_DEPTH = 4;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_e;

endpackage

// File: rtl/rr_arb.sv
// Combinational N-way round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arb #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  logic [W:0] pos;

  // Scan from ptr_i upward and take the first active request.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + (W+1)'(k);
      if (pos >= (W+1)'(N)) begin
        pos = pos - (W+1)'(N);
      end
      if (!vld_o && req_i[pos[W-1:0]]) begin
        vld_o              = 1'b1;
        gnt_o[pos[W-1:0]] = 1'b1;
        idx_o              = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/outputc_arb.sv
// Output-port allocator: wormhole lock per packet, round-robin across packets,
// credit-based flow control toward the downstream input buffer.
module outputc_arb
  import noc_pkg::*;
#(
  parameter int unsigned BUF_DEPTH_P = noc_pkg::BUF_DEPTH,
  localparam int unsigned CNT_W      = $clog2(BUF_DEPTH_P + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PORT_N-1:0] req_i,
  input  logic [PORT_N-1:0] flit_vld_i,
  input  logic [PORT_N-1:0] flit_tail_i,
  input  logic              credit_i,
  output logic [PORT_N-1:0] grant_o,
  output logic [PORT_W-1:0] grant_port_o,
  output logic              send_o,
  output logic [CNT_W-1:0]  credit_o,
  output logic              busy_o,
  output logic              err_o
);

  arb_state_e          state_q, state_d;
  logic [PORT_W-1:0]   owner_q, owner_d;
  logic [PORT_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]    credit_q, credit_d;
  logic                err_q, err_d;

  logic [PORT_N-1:0]   pick_gnt;
  logic [PORT_W-1:0]   pick_idx;
  logic                pick_vld;
  logic [PORT_N-1:0]   owner_oh;
  logic                locked;

  rr_arb #(
    .N (PORT_N),
    .W (PORT_W)
  ) u_rr_arb (
    .req_i (req_i),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // Owner decode and outputs; all zero while idle.
  always_comb begin
    locked   = (state_q == ARB_LOCK);
    owner_oh = '0;
    if (locked) begin
      owner_oh[owner_q] = 1'b1;
    end
    grant_o      = owner_oh;
    grant_port_o = locked ? owner_q : '0;
    busy_o       = locked;
    send_o       = locked && flit_vld_i[owner_q] && (credit_q != '0);
    credit_o     = credit_q;
    err_o        = err_q;
  end

  // Lock FSM: grant is registered; tail transfer releases and advances the pointer.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          state_d = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        if (send_o && flit_tail_i[owner_q]) begin
          state_d = ARB_IDLE;
          rr_d    = (owner_q == PORT_W'(PORT_N - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Credit counter and sticky error.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (send_o && !credit_i) begin
      credit_d = credit_q - 1'b1;
    end else if (credit_i && !send_o) begin
      if (credit_q == CNT_W'(BUF_DEPTH_P)) begin
        err_d = 1'b1;
      end else begin
        credit_d = credit_q + 1'b1;
      end
    end
    // Flit from a channel that neither owns the port nor requests it.
    if (locked && |(flit_vld_i & ~req_i & ~owner_oh)) begin
      err_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      credit_q <= CNT_W'(BUF_DEPTH_P);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_outputc_arb.sv
// Directed bench for outputc_arb.
module tb_outputc_arb;

  logic       clk;
  logic       rst_n;
  logic [4:0] req_i;
  logic [4:0] flit_vld_i;
  logic [4:0] flit_tail_i;
  logic       credit_i;
  logic [4:0] grant_o;
  logic [2:0] grant_port_o;
  logic       send_o;
  logic [2:0] credit_o;
  logic       busy_o;
  logic       err_o;

  int errors = 0;
  int checks = 0;

  outputc_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .flit_vld_i   (flit_vld_i),
    .flit_tail_i  (flit_tail_i),
    .credit_i     (credit_i),
    .grant_o      (grant_o),
    .grant_port_o (grant_port_o),
    .send_o       (send_o),
    .credit_o     (credit_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench 1 time unit after the first posedge following release.
  task automatic do_reset();
    req_i       = '0;
    flit_vld_i  = '0;
    flit_tail_i = '0;
    credit_i    = 1'b0;
    rst_n       = 1'b0;
    #7;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant_o !== 5'b0) begin errors++; $display("FAIL rst_grant got=%b exp=%b", grant_o, 5'b0); end
    checks++; if (grant_port_o !== 3'd0) begin errors++; $display("FAIL rst_port got=%0d exp=0", grant_port_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (send_o !== 1'b0) begin errors++; $display("FAIL rst_send got=%b exp=0", send_o); end
    checks++; if (credit_o !== 3'd4) begin errors++; $display("FAIL rst_credit got=%0d exp=4", credit_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err_o); end
    // Lock ch0, send one flit, then reset asynchronously mid-packet.
    req_i = 5'b00001;
    @(posedge clk) #1;
    req_i = '0; flit_vld_i = 5'b00001;
    @(posedge clk) #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy_o); end
    checks++; if (credit_o !== 3'd3) begin errors++; $display("FAIL mid_credit got=%0d exp=3", credit_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (grant_o !== 5'b0) begin errors++; $display("FAIL async_grant got=%b exp=%b", grant_o, 5'b0); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL async_busy got=%b exp=0", busy_o); end
    checks++; if (credit_o !== 3'd4) begin errors++; $display("FAIL async_credit got=%0d exp=4", credit_o); end
    flit_vld_i = '0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    req_i = 5'b10100;
    @(negedge clk);
    checks++; if (grant_o !== 5'b0) begin errors++; $display("FAIL basic_pregrant got=%b exp=%b", grant_o, 5'b0); end
    @(posedge clk) #1;
    req_i = 5'b10000; flit_vld_i = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      flit_tail_i = (i == 2) ? 5'b00100 : 5'b0;
      @(negedge clk);
      checks++; if (grant_o !== 5'b00100) begin errors++; $display("FAIL basic_grant[%0d] got=%b exp=00100", i, grant_o); end
      checks++; if (grant_port_o !== 3'd2) begin errors++; $display("FAIL basic_port[%0d] got=%0d exp=2", i, grant_port_o); end
      checks++; if (send_o !== 1'b1) begin errors++; $display("FAIL basic_send[%0d] got=%b exp=1", i, send_o); end
      checks++; if (credit_o !== 3'(4 - i)) begin errors++; $display("FAIL basic_credit[%0d] got=%0d exp=%0d", i, credit_o, 4 - i); end
      @(posedge clk) #1;
    end
    flit_vld_i = '0; flit_tail_i = '0;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_gap_busy got=%b exp=0", busy_o); end
    checks++; if (grant_o !== 5'b0) begin errors++; $display("FAIL basic_gap_grant got=%b exp=%b", grant_o, 5'b0); end
    checks++; if (credit_o !== 3'd1) begin errors++; $display("FAIL basic_gap_credit got=%0d exp=1", credit_o); end
    @(posedge clk) #1;
    @(negedge clk);
    checks++; if (grant_o !== 5'b10000) begin errors++; $display("FAIL basic_next_grant got=%b exp=10000", grant_o); end
    checks++; if (grant_port_o !== 3'd4) begin errors++; $display("FAIL basic_next_port got=%0d exp=4", grant_port_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", err_o); end
  endtask

  task automatic test_rr_all();
    logic [4:0] exp_g;
    do_reset();
    req_i = 5'b11111; flit_vld_i = 5'b11111; flit_tail_i = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      exp_g = 5'b00001 << (k % 5);
      @(posedge clk) #1;
      credit_i = 1'b1;
      @(negedge clk);
      checks++; if (grant_o !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, grant_o, exp_g); end
      checks++; if (send_o !== 1'b1) begin errors++; $display("FAIL rr_send[%0d] got=%b exp=1", k, send_o); end
      @(posedge clk) #1;
      credit_i = 1'b0;
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d] got=%b exp=0", k, busy_o); end
    end
    checks++; if (credit_o !== 3'd4) begin errors++; $display("FAIL rr_credit got=%0d exp=4", credit_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rr_err got=%b exp=0", err_o); end
  endtask

  task automatic test_credit();
    do_reset();
    req_i = 5'b00001;
    @(posedge clk) #1;
    req_i = '0; flit_vld_i = 5'b00001; flit_tail_i = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (send_o !== 1'b1) begin errors++; $display("FAIL cr_send[%0d] got=%b exp=1", i, send_o); end
      checks++; if (credit_o !== 3'(4 - i)) begin errors++; $display("FAIL cr_credit[%0d] got=%0d exp=%0d", i, credit_o, 4 - i); end
      @(posedge clk) #1;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (send_o !== 1'b0) begin errors++; $display("FAIL cr_stall_send[%0d] got=%b exp=0", i, send_o); end
      checks++; if (credit_o !== 3'd0) begin errors++; $display("FAIL cr_stall_credit[%0d] got=%0d exp=0", i, credit_o); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL cr_stall_busy[%0d] got=%b exp=1", i, busy_o); end
      @(posedge clk) #1;
    end
    credit_i = 1'b1;
    @(negedge clk);
    checks++; if (send_o !== 1'b0) begin errors++; $display("FAIL cr_ret_send got=%b exp=0", send_o); end
    // Keep credit_i high: the 5th flit goes out alongside a returning credit.
    @(posedge clk) #1;
    @(negedge clk);
    checks++; if (send_o !== 1'b1) begin errors++; $display("FAIL cr_5th_send got=%b exp=1", send_o); end
    checks++; if (credit_o !== 3'd1) begin errors++; $display("FAIL cr_5th_credit got=%0d exp=1", credit_o); end
    @(posedge clk) #1;
    credit_i = 1'b0; flit_tail_i = 5'b00001;
    @(negedge clk);
    checks++; if (credit_o !== 3'd1) begin errors++; $display("FAIL cr_same_credit got=%0d exp=1", credit_o); end
    checks++; if (send_o !== 1'b1) begin errors++; $display("FAIL cr_6th_send got=%b exp=1", send_o); end
    @(posedge clk) #1;
    flit_vld_i = '0; flit_tail_i = '0;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL cr_end_busy got=%b exp=0", busy_o); end
    checks++; if (credit_o !== 3'd0) begin errors++; $display("FAIL cr_end_credit got=%0d exp=0", credit_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL cr_end_err got=%b exp=0", err_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    credit_i = 1'b1;
    @(posedge clk) #1;
    credit_i = 1'b0;
    @(negedge clk);
    checks++; if (credit_o !== 3'd4) begin errors++; $display("FAIL ovf_credit got=%0d exp=4", credit_o); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ovf_err got=%b exp=1", err_o); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", err_o); end
    do_reset();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", err_o); end
  endtask

  task automatic test_nonowner_err();
    do_reset();
    req_i = 5'b00010;
    @(posedge clk) #1;
    req_i = '0; flit_vld_i = 5'b00011; flit_tail_i = '0;
    @(negedge clk);
    checks++; if (grant_o !== 5'b00010) begin errors++; $display("FAIL no_grant got=%b exp=00010", grant_o); end
    checks++; if (send_o !== 1'b1) begin errors++; $display("FAIL no_send got=%b exp=1", send_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL no_err_pre got=%b exp=0", err_o); end
    @(posedge clk) #1;
    flit_vld_i = 5'b00010;
    @(negedge clk);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL no_err got=%b exp=1", err_o); end
    checks++; if (send_o !== 1'b1) begin errors++; $display("FAIL no_send2 got=%b exp=1", send_o); end
    checks++; if (credit_o !== 3'd3) begin errors++; $display("FAIL no_credit got=%0d exp=3", credit_o); end
  endtask

  initial begin
    rst_n       = 1'b0;
    req_i       = '0;
    flit_vld_i  = '0;
    flit_tail_i = '0;
    credit_i    = 1'b0;
    test_reset();
    test_basic();
    test_rr_all();
    test_credit();
    test_overflow();
    test_nonowner_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
